register_file_sb: RTL and testbench
===================================

REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 18, data width of every register.
REQ-002 SHALL provide parameter DEPTH, default 16, number of registers; legal values are powers of two from 2 to 64.
REQ-003 SHALL provide parameter ADDR_W, default 4, register address width, equal to log2(DEPTH).
REQ-004 SHALL provide parameter ZERO_REG, default 0; when 1, register 0 reads as zero and is never written or marked pending.
REQ-005 SHALL provide parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port RegWrite, input, 1 bit: writeback enable.
REQ-009 SHALL have port write_addr, input, ADDR_W bits: writeback register index.
REQ-010 SHALL have port write_data, input, DATA_W bits: writeback data.
REQ-011 SHALL have port issue_valid, input, 1 bit: marks issue_addr as pending (result outstanding).
REQ-012 SHALL have port issue_addr, input, ADDR_W bits: destination register being issued.
REQ-013 SHALL have ports rs1 and rs2, input, ADDR_W bits each: read addresses.
REQ-014 SHALL have ports rd1 and rd2, output, DATA_W bits each: read data.
REQ-015 SHALL have ports rd1_ok and rd2_ok, output, 1 bit each: 1 when the matching rdN holds the current, non-pending value.
REQ-016 SHALL have port pending_cnt, output, ADDR_W+1 bits: number of registers currently pending.

Function
REQ-017 SHALL write write_data into regs[write_addr] on a rising clk edge when RegWrite=1, with write_addr=0 ignored when ZERO_REG=1.
REQ-018 SHALL drive rdN combinationally as follows, in priority order: zero if ZERO_REG=1 and rsN=0; else write_data if BYPASS=1, RegWrite=1 and write_addr=rsN; else regs[rsN].
REQ-019 SHALL maintain one pending bit per register: set at a clk edge by issue_valid for issue_addr, cleared by RegWrite for write_addr.
REQ-020 SHALL give set priority when issue and writeback target the same register in the same cycle, so the bit ends at 1 because the new producer is outstanding.
REQ-021 SHALL never set the pending bit of register 0 when ZERO_REG=1.
REQ-022 SHALL treat a writeback to a non-pending register as a legal plain write that leaves the pending bit at 0.
REQ-023 SHALL treat an issue to an already-pending register as leaving the bit at 1, with no count change.
REQ-024 SHALL drive rdN_ok=1 when any of these holds: the pending bit of rsN is 0; BYPASS=1 and a same-cycle writeback hits rsN; ZERO_REG=1 and rsN=0.
REQ-025 SHALL, when BYPASS=0, drive rdN_ok=0 for a pending rsN even under a same-cycle writeback, and let rdN show the old register value.
REQ-026 SHALL register pending_cnt so it equals the popcount of the pending bits after each clk edge, staying within 0..DEPTH with no wrap.
REQ-027 SHALL update pending_cnt at a clk edge by +1 for a new set, -1 for a clear, and by 0 for a set and clear of different registers or for the REQ-020 same-register case.
REQ-028 SHALL have zero read latency: rd/ok outputs are combinational from rsN, state and the same-cycle writeback inputs.

Reset
REQ-029 SHALL, while reset_n=0, clear all registers, all pending bits and pending_cnt to 0 asynchronously, regardless of clk.
REQ-030 SHALL, while reset_n=0, drive rdN to the BYPASS forward of write_data when RegWrite=1 hits rsN, and to 0 otherwise.
REQ-031 SHALL, while reset_n=0, drive rdN_ok=1 and ignore all writes and issues.
REQ-032 SHALL discard in-flight issues on reset assertion mid-operation, with no state retained.
REQ-033 SHALL resume normal operation at the first rising clk edge after reset_n deasserts.

Verification
REQ-034 SHALL be covered by this scenario: reset, then write 18'h3FFFF to r5 and read rs1=5 next cycle -> rd1=18'h3FFFF, rd1_ok=1.
REQ-035 SHALL be covered by this scenario: issue r7 with one edge elapsed, rs2=7 -> rd2_ok=0 and pending_cnt=1; writeback r7=18'h00123 with BYPASS=1 -> same cycle rd2=18'h00123, rd2_ok=1, and pending_cnt=0 after the edge.
REQ-036 SHALL be covered by this scenario: issue r3 and writeback r3 in the same cycle -> r3 still pending with pending_cnt unchanged, and a later writeback r3 clears it.
REQ-037 SHALL be covered by this scenario: ZERO_REG=1, write 18'h0ABCD to r0 and issue r0 -> rd1(rs1=0)=0, rd1_ok=1, pending_cnt=0.
REQ-038 SHALL be covered by this scenario: issue all DEPTH registers over DEPTH cycles -> pending_cnt=DEPTH with no wrap, then assert reset_n=0 mid-sequence -> pending_cnt=0 and all regs 0 immediately.
REQ-039 SHALL be covered by this scenario: BYPASS=0, pending r2, same-cycle writeback r2 with rs1=2 -> rd1 holds the old value, rd1_ok=0, and the next cycle gives the new value with rd1_ok=1.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: scoreboarded register file with pending-result tracking and write bypass
// Rev 1.0
`default_nettype none

module register_file_sb #(
   parameter int DATA_W   = 18,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              rd1_ok,
   output logic              rd2_ok,
   output logic [ADDR_W:0]   pending_cnt
);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   logic wr_en, iss_en, set_new, clr_real;

   // Register 0 is hardwired when ZERO_REG is set: neither written nor tracked.
   assign wr_en  = RegWrite    && !(ZERO_REG && (write_addr == '0));
   assign iss_en = issue_valid && !(ZERO_REG && (issue_addr == '0));

   // A same-register issue wins over the writeback, so that clear is not a real clear.
   assign set_new  = iss_en && !pend_q[issue_addr];
   assign clr_real = wr_en && pend_q[write_addr] && !(iss_en && (issue_addr == write_addr));

   always_comb begin
      pend_d = pend_q;
      if (wr_en)  pend_d[write_addr] = 1'b0;
      if (iss_en) pend_d[issue_addr] = 1'b1;
      cnt_d = cnt_q + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_real};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_en) regs_q[write_addr] <= write_data;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pending_cnt = cnt_q;

   logic [ADDR_W-1:0] rs_a [2];
   logic [DATA_W-1:0] rd_a [2];
   logic              ok_a [2];

   assign rs_a[0] = rs1;
   assign rs_a[1] = rs2;

   for (genvar p = 0; p < 2; p++) begin : g_rd_port
      logic hit_zero, hit_fwd;
      assign hit_zero = ZERO_REG && (rs_a[p] == '0);
      assign hit_fwd  = BYPASS && RegWrite && (write_addr == rs_a[p]);
      assign rd_a[p]  = hit_zero ? '0 : (hit_fwd ? write_data : regs_q[rs_a[p]]);
      assign ok_a[p]  = hit_zero || hit_fwd || !pend_q[rs_a[p]];
   end

   assign rd1    = rd_a[0];
   assign rd2    = rd_a[1];
   assign rd1_ok = ok_a[0];
   assign rd2_ok = ok_a[1];

endmodule

`default_nettype wire

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed checks of register_file_sb in default, ZERO_REG=1 and BYPASS=0 builds
`default_nettype none

module tb_register_file_sb;

   logic        clk, reset_n, RegWrite, issue_valid;
   logic [3:0]  write_addr, issue_addr, rs1, rs2;
   logic [17:0] write_data;

   logic [17:0] d_rd1, d_rd2, z_rd1, z_rd2, n_rd1, n_rd2;
   logic        d_ok1, d_ok2, z_ok1, z_ok2, n_ok1, n_ok2;
   logic [4:0]  d_cnt, z_cnt, n_cnt;

   int tests = 0;
   int fails = 0;

   register_file_sb #(.DATA_W(18), .DEPTH(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut (
      .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .write_addr(write_addr),
      .write_data(write_data), .issue_valid(issue_valid), .issue_addr(issue_addr),
      .rs1(rs1), .rs2(rs2), .rd1(d_rd1), .rd2(d_rd2), .rd1_ok(d_ok1), .rd2_ok(d_ok2),
      .pending_cnt(d_cnt));

   register_file_sb #(.DATA_W(18), .DEPTH(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_zr (
      .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .write_addr(write_addr),
      .write_data(write_data), .issue_valid(issue_valid), .issue_addr(issue_addr),
      .rs1(rs1), .rs2(rs2), .rd1(z_rd1), .rd2(z_rd2), .rd1_ok(z_ok1), .rd2_ok(z_ok2),
      .pending_cnt(z_cnt));

   register_file_sb #(.DATA_W(18), .DEPTH(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
      .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .write_addr(write_addr),
      .write_data(write_data), .issue_valid(issue_valid), .issue_addr(issue_addr),
      .rs1(rs1), .rs2(rs2), .rd1(n_rd1), .rd2(n_rd2), .rd1_ok(n_ok1), .rd2_ok(n_ok2),
      .pending_cnt(n_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      RegWrite    = 1'b0;
      issue_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; rs1 = 4'd5; rs2 = 4'd0;
      RegWrite = 1'b1; write_addr = 4'd5; write_data = 18'h2AAAA;
      issue_valid = 1'b1; issue_addr = 4'd5;
      #2;
      tests++; if (d_rd1 !== 18'h2AAAA) begin fails++; $display("FAIL rst_fwd rd1 got %h exp %h", d_rd1, 18'h2AAAA); end
      tests++; if (d_ok1 !== 1'b1) begin fails++; $display("FAIL rst_ok rd1_ok got %b exp 1", d_ok1); end
      tests++; if (n_rd1 !== 18'h0) begin fails++; $display("FAIL rst_nobyp rd1 got %h exp 0", n_rd1); end
      tests++; if (d_cnt !== 5'd0) begin fails++; $display("FAIL rst_cnt cnt got %0d exp 0", d_cnt); end
      tick();
      idle();
      #1;
      tests++; if (d_rd1 !== 18'h0) begin fails++; $display("FAIL rst_ignwr rd1 got %h exp 0", d_rd1); end
      tests++; if (d_cnt !== 5'd0) begin fails++; $display("FAIL rst_ignis cnt got %0d exp 0", d_cnt); end
      reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      do_reset();
      RegWrite = 1'b1; write_addr = 4'd5; write_data = 18'h3FFFF;
      tick();
      idle(); rs1 = 4'd5;
      #1;
      tests++; if (d_rd1 !== 18'h3FFFF) begin fails++; $display("FAIL wr_rd rd1 got %h exp %h", d_rd1, 18'h3FFFF); end
      tests++; if (d_ok1 !== 1'b1) begin fails++; $display("FAIL wr_rd_ok rd1_ok got %b exp 1", d_ok1); end
   endtask

   task automatic test_pending_bypass();
      do_reset();
      issue_valid = 1'b1; issue_addr = 4'd7;
      tick();
      idle(); rs2 = 4'd7;
      #1;
      tests++; if (d_ok2 !== 1'b0) begin fails++; $display("FAIL pend_ok rd2_ok got %b exp 0", d_ok2); end
      tests++; if (d_cnt !== 5'd1) begin fails++; $display("FAIL pend_cnt cnt got %0d exp 1", d_cnt); end
      RegWrite = 1'b1; write_addr = 4'd7; write_data = 18'h00123;
      #1;
      tests++; if (d_rd2 !== 18'h00123) begin fails++; $display("FAIL byp_rd rd2 got %h exp %h", d_rd2, 18'h00123); end
      tests++; if (d_ok2 !== 1'b1) begin fails++; $display("FAIL byp_ok rd2_ok got %b exp 1", d_ok2); end
      tests++; if (n_ok2 !== 1'b0 || n_rd2 !== 18'h0) begin fails++; $display("FAIL nobyp_rd rd2 got %h/%b exp 0/0", n_rd2, n_ok2); end
      tick();
      idle();
      #1;
      tests++; if (d_cnt !== 5'd0) begin fails++; $display("FAIL wb_cnt cnt got %0d exp 0", d_cnt); end
      tests++; if (n_rd2 !== 18'h00123 || n_ok2 !== 1'b1) begin fails++; $display("FAIL wb_rd rd2 got %h/%b exp 00123/1", n_rd2, n_ok2); end
   endtask

   task automatic test_same_reg();
      do_reset();
      issue_valid = 1'b1; issue_addr = 4'd3;
      tick();
      idle(); rs1 = 4'd3; rs2 = 4'd4;
      #1;
      tests++; if (d_cnt !== 5'd1 || d_ok1 !== 1'b0) begin fails++; $display("FAIL same_pre cnt/ok got %0d/%b exp 1/0", d_cnt, d_ok1); end
      issue_valid = 1'b1; issue_addr = 4'd3;
      RegWrite = 1'b1; write_addr = 4'd3; write_data = 18'h11111;
      tick();
      idle();
      #1;
      tests++; if (d_cnt !== 5'd1) begin fails++; $display("FAIL same_cnt cnt got %0d exp 1", d_cnt); end
      tests++; if (d_ok1 !== 1'b0 || d_rd1 !== 18'h11111) begin fails++; $display("FAIL same_pend rd1 got %h/%b exp 11111/0", d_rd1, d_ok1); end
      issue_valid = 1'b1; issue_addr = 4'd4;
      RegWrite = 1'b1; write_addr = 4'd3; write_data = 18'h22222;
      tick();
      idle();
      #1;
      tests++; if (d_cnt !== 5'd1) begin fails++; $display("FAIL diff_cnt cnt got %0d exp 1", d_cnt); end
      tests++; if (d_ok1 !== 1'b1 || d_rd1 !== 18'h22222) begin fails++; $display("FAIL clr_rd rd1 got %h/%b exp 22222/1", d_rd1, d_ok1); end
      tests++; if (d_ok2 !== 1'b0) begin fails++; $display("FAIL diff_ok rd2_ok got %b exp 0", d_ok2); end
      RegWrite = 1'b1; write_addr = 4'd4; write_data = 18'h00044;
      tick();
      idle();
      #1;
      tests++; if (d_cnt !== 5'd0) begin fails++; $display("FAIL clr4_cnt cnt got %0d exp 0", d_cnt); end
      RegWrite = 1'b1; write_addr = 4'd9; write_data = 18'h00009;
      tick();
      idle();
      #1;
      tests++; if (d_cnt !== 5'd0) begin fails++; $display("FAIL plainwr_cnt cnt got %0d exp 0", d_cnt); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      rs1 = 4'd0;
      RegWrite = 1'b1; write_addr = 4'd0; write_data = 18'h0ABCD;
      issue_valid = 1'b1; issue_addr = 4'd0;
      #1;
      tests++; if (z_rd1 !== 18'h0 || z_ok1 !== 1'b1) begin fails++; $display("FAIL zr_same rd1 got %h/%b exp 0/1", z_rd1, z_ok1); end
      tick();
      idle();
      #1;
      tests++; if (z_rd1 !== 18'h0 || z_ok1 !== 1'b1) begin fails++; $display("FAIL zr_rd rd1 got %h/%b exp 0/1", z_rd1, z_ok1); end
      tests++; if (z_cnt !== 5'd0) begin fails++; $display("FAIL zr_cnt cnt got %0d exp 0", z_cnt); end
      tests++; if (d_rd1 !== 18'h0ABCD || d_ok1 !== 1'b0 || d_cnt !== 5'd1) begin fails++; $display("FAIL r0_norm rd1/ok/cnt got %h/%b/%0d exp 0abcd/0/1", d_rd1, d_ok1, d_cnt); end
   endtask

   task automatic test_fill_reset();
      do_reset();
      RegWrite = 1'b1; write_addr = 4'd1; write_data = 18'h01234;
      tick();
      idle(); rs1 = 4'd1;
      for (int i = 0; i < 16; i++) begin
         issue_valid = 1'b1; issue_addr = 4'(i);
         tick();
         idle();
         #1;
         tests++; if (d_cnt !== 5'(i + 1)) begin fails++; $display("FAIL fill_cnt[%0d] cnt got %0d exp %0d", i, d_cnt, i + 1); end
      end
      tests++; if (z_cnt !== 5'd15) begin fails++; $display("FAIL zr_fill cnt got %0d exp 15", z_cnt); end
      issue_valid = 1'b1; issue_addr = 4'd3;
      tick();
      issue_addr = 4'd5;
      #1;
      tests++; if (d_cnt !== 5'd16) begin fails++; $display("FAIL full_cnt cnt got %0d exp 16", d_cnt); end
      reset_n = 1'b0;
      #1;
      tests++; if (d_cnt !== 5'd0) begin fails++; $display("FAIL async_cnt cnt got %0d exp 0", d_cnt); end
      tests++; if (d_rd1 !== 18'h0 || d_ok1 !== 1'b1) begin fails++; $display("FAIL async_rd rd1 got %h/%b exp 0/1", d_rd1, d_ok1); end
      tick();
      reset_n = 1'b1;
      idle();
      tick();
      #1;
      tests++; if (d_cnt !== 5'd0) begin fails++; $display("FAIL resume_cnt cnt got %0d exp 0", d_cnt); end
   endtask

   task automatic test_no_bypass();
      do_reset();
      RegWrite = 1'b1; write_addr = 4'd2; write_data = 18'h0AAAA;
      tick();
      idle();
      issue_valid = 1'b1; issue_addr = 4'd2;
      tick();
      idle(); rs1 = 4'd2;
      RegWrite = 1'b1; write_addr = 4'd2; write_data = 18'h15555;
      #1;
      tests++; if (n_rd1 !== 18'h0AAAA || n_ok1 !== 1'b0) begin fails++; $display("FAIL nb_same rd1 got %h/%b exp 0aaaa/0", n_rd1, n_ok1); end
      tests++; if (d_rd1 !== 18'h15555 || d_ok1 !== 1'b1) begin fails++; $display("FAIL byp_same rd1 got %h/%b exp 15555/1", d_rd1, d_ok1); end
      tick();
      idle();
      #1;
      tests++; if (n_rd1 !== 18'h15555 || n_ok1 !== 1'b1) begin fails++; $display("FAIL nb_next rd1 got %h/%b exp 15555/1", n_rd1, n_ok1); end
      tests++; if (n_cnt !== 5'd0) begin fails++; $display("FAIL nb_cnt cnt got %0d exp 0", n_cnt); end
   endtask

   initial begin
      reset_n = 1'b0; RegWrite = 1'b0; issue_valid = 1'b0;
      write_addr = '0; issue_addr = '0; write_data = '0; rs1 = '0; rs2 = '0;
      test_reset();
      test_write_read();
      test_pending_bypass();
      test_same_reg();
      test_zero_reg();
      test_fill_reset();
      test_no_bypass();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
